// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the stopwatch front end:
//               debouncer FSM state encoding and default debounce / long-press
//               cycle counts for board and simulation builds.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  // Press/release FSM state encoding
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    PRESSED   = 2'd2,
    CHK_REL   = 2'd3
  } key_state_e;

  // Board build: 20000 cycles of stability, 1000000 cycles for a long press
  localparam int unsigned c_debounce_cycles_board = 20000;
  localparam int unsigned c_long_cycles_board     = 1000000;

  // Simulation build: short counts so corner cases are quick to exercise
  localparam int unsigned c_debounce_cycles_sim   = 4;
  localparam int unsigned c_long_cycles_sim       = 10;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous input bit.
//               Both flops reset asynchronously (active low) to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; second flop gives it a cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : Debounces one raw push-button into a clean level (key_out)
//               with a one-cycle key_changed pulse on every toggle.
//               Two-flop synchroniser, stability counter and a four-state
//               press/release FSM. Defining KEY_LONG_PRESS_EN adds a
//               long_press output that pulses once per press after key_out
//               has been high for LONG_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned LONG_CYCLES     = 1000000,
`ifdef KEY_LONG_PRESS_EN
  parameter int unsigned CNT_W           = $clog2(LONG_CYCLES + 1)
`else
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_out,
  output logic key_changed
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Illegal configurations stop elaboration rather than build a broken counter
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
    $error("key_debouncer: DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES < 2) begin : g_chk_long
    $error("key_debouncer: LONG_CYCLES must be at least 2");
  end

  logic       w_key_s;
  key_state_e r_state;
  key_state_e w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic       r_key_out;
  logic       w_key_out_nxt;
  logic       r_key_changed;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (w_key_s)
  );

  // State, stability counter and debounced level; key_changed marks a toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= c_cnt_zero;
      r_key_out     <= 1'b0;
      r_key_changed <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_key_out     <= w_key_out_nxt;
      r_key_changed <= (w_key_out_nxt != r_key_out);
    end
  end

  // Next state: any opposite sample in a CHK state restarts from scratch
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_key_out_nxt = r_key_out;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = c_cnt_zero;
        if (w_key_s) begin
          w_state_nxt = CHK_PRESS;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      CHK_PRESS: begin
        if (!w_key_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = c_cnt_zero;
        end else if (r_cnt == c_deb_last) begin
          w_state_nxt   = PRESSED;
          w_key_out_nxt = 1'b1;
          w_cnt_nxt     = c_cnt_zero;
        end else if (r_cnt != c_cnt_max) begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      PRESSED: begin
        if (!w_key_s) begin
          w_state_nxt = CHK_REL;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      CHK_REL: begin
        if (w_key_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = c_cnt_zero;
        end else if (r_cnt == c_deb_last) begin
          w_state_nxt   = IDLE;
          w_key_out_nxt = 1'b0;
          w_cnt_nxt     = c_cnt_zero;
        end else if (r_cnt != c_cnt_max) begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_cnt_nxt     = c_cnt_zero;
        w_key_out_nxt = 1'b0;
      end
    endcase
  end

  assign key_out     = r_key_out;
  assign key_changed = r_key_changed;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] r_long_cnt;
  logic             r_long_fired;
  logic             r_long_press;

  // Long-press timer runs while key_out is high (release bounces included),
  // saturates, fires once, and re-arms only when key_out returns low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_long_cnt   <= c_cnt_zero;
      r_long_fired <= 1'b0;
      r_long_press <= 1'b0;
    end else if (!r_key_out) begin
      r_long_cnt   <= c_cnt_zero;
      r_long_fired <= 1'b0;
      r_long_press <= 1'b0;
    end else begin
      r_long_press <= 1'b0;
      if (r_long_cnt != c_long_last) begin
        r_long_cnt <= r_long_cnt + c_cnt_one;
      end else if (!r_long_fired) begin
        r_long_press <= 1'b1;
        r_long_fired <= 1'b1;
      end
    end
  end

  assign long_press = r_long_press;
`endif

endmodule
`default_nettype wire

// File: doc/key_debouncer.md
# key_debouncer

Debounces one raw mechanical push-button input into a clean, glitch-free level for the stopwatch front end. It sits directly upstream of the edge-catching stage: its `key_out` level feeds that stage's input, which turns the debounced release into a single-cycle event. Internally it has a two-flop synchroniser, a stability counter and a four-state press/release FSM, plus an optional long-press detector.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable cycles (post-sync) required before `key_out` changes; legal range ≥ 2.
- `LONG_CYCLES`, default 1000000: cycles `key_out` must stay high before `long_press` fires; only meaningful with `KEY_LONG_PRESS_EN`.
- `CNT_W`, default `$clog2(LONG_CYCLES+1)`: stability/long counter width.

- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_in` in 1: raw button, asynchronous, 1 = pressed.
- `key_out` out 1: debounced level, 1 = pressed.
- `key_changed` out 1: single-cycle pulse on the cycle `key_out` toggles.
- `long_press` out 1: single-cycle pulse, at most once per press (exists only with `KEY_LONG_PRESS_EN`).

## Operation
- Reset: sync flops = 0, FSM = IDLE, counter = 0, `key_out` = 0, `key_changed` = 0, `long_press` = 0. Reset asserted mid-operation aborts any count immediately; after release, the block behaves as if the key were released.
- `key_s` = `key_in` after two flops.
- FSM states:
  - IDLE (`key_out`=0): if `key_s`=1 → CHK_PRESS, counter ← 1.
  - CHK_PRESS: `key_s`=0 → IDLE, counter ← 0 (bounce). `key_s`=1 and counter = DEBOUNCE_CYCLES−1 → PRESSED, `key_out` ← 1, counter ← 0. Otherwise counter +1.
  - PRESSED (`key_out`=1): if `key_s`=0 → CHK_REL, counter ← 1.
  - CHK_REL: mirror of CHK_PRESS; `key_s`=1 → PRESSED (`key_out` stays 1); full count → IDLE, `key_out` ← 0.
- `key_changed` is high exactly on the cycle after the edge where `key_out` was updated, i.e. it is registered alongside `key_out` and coincides with the new value.
- Counter saturates. It never wraps.
- Any single sample of the opposite level during a CHK state restarts the debounce from scratch. No hysteresis is carried over.

## Timing
- With `key_in` stable after a change, `key_out` takes its new value on the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples the change. The 2 cycles are the synchroniser.
- A glitch shorter than DEBOUNCE_CYCLES cycles (post-sync) never reaches `key_out`.
- `key_changed` and `long_press` are always exactly 1 cycle wide.
- `key_out` never toggles more often than once per DEBOUNCE_CYCLES cycles.

## Configuration
- `KEY_LONG_PRESS_EN` defined:
  - In PRESSED, the counter counts cycles since entry.
  - When it reaches LONG_CYCLES−1, `long_press` pulses once and the counter saturates.
  - The pulse is re-armed only by returning to IDLE.
  - Time spent in CHK_REL that bounces back to PRESSED does not reset the long count.
- `KEY_LONG_PRESS_EN` undefined:
  - The `long_press` port and its logic are absent.
  - The counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

## Structure
- Shared package `stopwatch_pkg`: FSM state encoding (IDLE=2'd0, CHK_PRESS=2'd1, PRESSED=2'd2, CHK_REL=2'd3), default DEBOUNCE_CYCLES/LONG_CYCLES constants for board and simulation builds.
- Sub-module `sync_2ff`: two-flop synchroniser with async active-low reset to 0, reusable by other button inputs.

## Test plan
DEBOUNCE_CYCLES=4, LONG_CYCLES=10 for simulation:
- Reset with `key_in`=1 held → all outputs 0 during reset. After `rst_n` rises, `key_out`=1 on the 6th edge, with `key_changed` pulsing that cycle.
- Clean press: `key_in` 0→1 held 20 cycles → `key_out`=1 exactly 6 edges after the change, one `key_changed` pulse, no further toggles.
- Bounce: `key_in` toggles 1,0,1,0 every 2 cycles, then settles at 1 → `key_out` stays 0 through the bounces and rises 6 cycles after settling.
- Release glitch: while pressed, `key_in`=0 for 3 cycles, then 1 → `key_out` stays 1, no `key_changed`. Then a sustained 0 → `key_out` falls after 6 cycles.
- Long press (`KEY_LONG_PRESS_EN`): hold 30 cycles after debounce → exactly one `long_press` pulse, 10 cycles after `key_out` rose. Release and press again → a second pulse.
- Reset mid-count: assert `rst_n`=0 during CHK_PRESS (counter=2) → `key_out`=0 immediately. After release with `key_in`=1, the full 6-cycle latency restarts.
